mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 21 ++
 rtl/mem_responder.sv | 96 +++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU datapath (master) and the
// wait-state memory responder (slave).
interface mem_responder_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        err;

    modport master (
        output memread, memwrite, addr, writedata,
        input  readdata, ready, err
    );

    modport slave (
        input  memread, memwrite, addr, writedata,
        output readdata, ready, err
    );
endinterface

// File: rtl/mem_responder.sv
// Wait-state memory responder: latches one load/store, holds it for WAIT
// cycles, then answers with a one-cycle ready strobe plus data and error flag.
module mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [31:0] LIMIT    = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, next_state;
    logic [3:0]    wait_cnt;
    logic          op_read, op_write;
    logic [31:0]   op_addr, op_wdata;
    logic [31:0]   resp_data;
    logic          resp_err;
    logic          req_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   mem [DEPTH];

    // Errors are judged on the latched request only, never on live inputs.
    assign req_err  = (op_read & op_write) | (op_addr[1:0] != 2'b00) | (op_addr >= LIMIT);
    assign word_idx = op_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.memread | bus.memwrite) next_state = BUSY;
            BUSY:    if (wait_cnt == 4'd0) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            op_read   <= 1'b0;
            op_write  <= 1'b0;
            op_addr   <= 32'd0;
            op_wdata  <= 32'd0;
            resp_data <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.memread | bus.memwrite) begin
                        op_read  <= bus.memread;
                        op_write <= bus.memwrite;
                        op_addr  <= bus.addr;
                        op_wdata <= bus.writedata;
                        wait_cnt <= WAIT_CNT;
                    end
                end
                BUSY: begin
                    if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
                end
                default: ;
            endcase

            // Response registers are only non-zero for the single RESP cycle.
            if (state == BUSY && wait_cnt == 4'd0) begin
                resp_err  <= req_err;
                resp_data <= (op_read & ~req_err) ? mem[word_idx] : 32'd0;
            end else begin
                resp_err  <= 1'b0;
                resp_data <= 32'd0;
            end
        end
    end

    // Storage has no reset; an async reset drops state out of RESP, cancelling the commit.
    always_ff @(posedge clk) begin
        if (state == RESP && op_write && !req_err) begin
            mem[word_idx] <= op_wdata;
        end
    end

    assign bus.ready    = (state == RESP);
    assign bus.readdata = resp_data;
    assign bus.err      = resp_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT=2, 0, 1) driven by directed
// scenarios and random traffic, checked against a word-array reference model.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rstn [3];
    logic        rd [3];
    logic        wr [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic [31:0] rdata [3];
    logic        rdy [3];
    logic        er [3];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int wait_of [3] = '{2, 0, 1};

    logic [31:0] model_mem   [3][256];
    bit          model_valid [3][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();
    mem_responder_if bus2 ();

    assign bus0.memread = rd[0]; assign bus0.memwrite = wr[0]; assign bus0.addr = ad[0]; assign bus0.writedata = wd[0];
    assign bus1.memread = rd[1]; assign bus1.memwrite = wr[1]; assign bus1.addr = ad[1]; assign bus1.writedata = wd[1];
    assign bus2.memread = rd[2]; assign bus2.memwrite = wr[2]; assign bus2.addr = ad[2]; assign bus2.writedata = wd[2];
    assign rdata[0] = bus0.readdata; assign rdy[0] = bus0.ready; assign er[0] = bus0.err;
    assign rdata[1] = bus1.readdata; assign rdy[1] = bus1.ready; assign er[1] = bus1.err;
    assign rdata[2] = bus2.readdata; assign rdy[2] = bus2.ready; assign er[2] = bus2.err;

    mem_responder #(.DEPTH(256), .WAIT(2)) dut0 (.clk(clk), .reset(rstn[0]), .bus(bus0.slave));
    mem_responder #(.DEPTH(256), .WAIT(0)) dut1 (.clk(clk), .reset(rstn[1]), .bus(bus1.slave));
    mem_responder #(.DEPTH(256), .WAIT(1)) dut2 (.clk(clk), .reset(rstn[2]), .bus(bus2.slave));

    // Issue one request, scramble the held address/data while busy, and report
    // response data, error, edges from accept to ready, and output hygiene.
    task automatic run_req(input int d, input logic r, input logic w, input logic [31:0] a,
                           input logic [31:0] data, output logic [31:0] got_data,
                           output logic got_err, output int edges, output bit quiet_ok,
                           output bit strobe_ok);
        @(negedge clk);
        rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = data;
        @(posedge clk);
        #1;
        ad[d] = $urandom; wd[d] = $urandom;
        edges = -1; quiet_ok = 1'b1; got_data = '0; got_err = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (rdy[d] === 1'b1) begin
                edges = i; got_data = rdata[d]; got_err = er[d];
                break;
            end
            if (rdata[d] !== 32'd0 || er[d] !== 1'b0) quiet_ok = 1'b0;
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge clk);
        #1;
        strobe_ok = (rdy[d] === 1'b0 && rdata[d] === 32'd0 && er[d] === 1'b0);
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; rd[d] = 1'b1; wr[d] = 1'b0; ad[d] = 32'h10; wd[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if ({rdy[d], er[d], rdata[d]} !== 34'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_outputs d%0d: got rdy=%b err=%b data=%h, want all 0", d, rdy[d], er[d], rdata[d]);
            end
            rd[d] = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
    endtask

    // Directed load/store scenarios with fixed expected values.
    task automatic test_directed(input int d, input logic r, input logic w, input logic [31:0] a,
                                 input logic [31:0] data, input logic [31:0] exp_data,
                                 input logic exp_err, input string name);
        logic [31:0] got_data; logic got_err; int edges; bit quiet_ok, strobe_ok;
        run_req(d, r, w, a, data, got_data, got_err, edges, quiet_ok, strobe_ok);
        vectors++;
        if (edges !== wait_of[d] + 1) begin
            miscompares++; $display("[TB] FAIL %s latency: got %0d edges, want %0d", name, edges, wait_of[d] + 1);
        end
        vectors++;
        if (got_err !== exp_err || got_data !== exp_data) begin
            miscompares++; $display("[TB] FAIL %s response: got err=%b data=%h, want err=%b data=%h", name, got_err, got_data, exp_err, exp_data);
        end
        vectors++;
        if (!quiet_ok || !strobe_ok) begin
            miscompares++; $display("[TB] FAIL %s strobe: got quiet=%b single=%b, want 1 1", name, quiet_ok, strobe_ok);
        end
        if (w && !r && !exp_err) begin
            model_mem[d][a[9:2]] = data; model_valid[d][a[9:2]] = 1'b1;
        end
    endtask

    task automatic test_basic();
        test_directed(0, 0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0, "store_10");
        test_directed(0, 1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, "load_10");
        test_directed(0, 0, 1, 32'h12,  32'h12345678, 32'h0,        1, "store_misaligned");
        test_directed(0, 1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, "load_10_unchanged");
        test_directed(0, 0, 1, 32'h20,  32'hCAFEF00D, 32'h0,        0, "store_20");
        test_directed(0, 1, 0, 32'h400, 32'h0,        32'h0,        1, "load_out_of_range");
        test_directed(0, 1, 1, 32'h20,  32'h0BADF00D, 32'h0,        1, "read_and_write");
        test_directed(0, 1, 0, 32'h20,  32'h0,        32'hCAFEF00D, 0, "load_20_unchanged");
        test_directed(1, 0, 1, 32'h10,  32'hDEADBEEF, 32'h0,        0, "w0_store_10");
        test_directed(1, 1, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, "w0_load_10");
    endtask

    task automatic test_reset_abort(input int abort_edges, input string name);
        bit saw_ready;
        @(negedge clk);
        wr[0] = 1'b1; rd[0] = 1'b0; ad[0] = 32'h40; wd[0] = 32'h11112222;
        @(posedge clk);
        repeat (abort_edges) @(posedge clk);
        #2;
        rstn[0] = 1'b0; wr[0] = 1'b0;
        #1;
        vectors++;
        if ({rdy[0], er[0], rdata[0]} !== 34'd0) begin
            miscompares++; $display("[TB] FAIL %s outputs_in_reset: got rdy=%b err=%b data=%h, want 0", name, rdy[0], er[0], rdata[0]);
        end
        saw_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (rdy[0] !== 1'b0) saw_ready = 1'b1;
        end
        vectors++;
        if (saw_ready) begin
            miscompares++; $display("[TB] FAIL %s ready_during_reset: got 1, want 0", name);
        end
        @(negedge clk);
        rstn[0] = 1'b1;
        test_directed(0, 1, 0, 32'h40, 32'h0, 32'hAAAA5555, 0, {name, "_load_40"});
    endtask

    task automatic test_back_to_back();
        int t [3]; logic [31:0] dat [3]; int pulses;
        test_directed(2, 0, 1, 32'h80, 32'hA5A50001, 32'h0, 0, "b2b_store_80");
        test_directed(2, 0, 1, 32'h84, 32'h5A5A0002, 32'h0, 0, "b2b_store_84");
        @(negedge clk);
        rd[2] = 1'b1; wr[2] = 1'b0; ad[2] = 32'h80;
        @(posedge clk);
        #1;
        ad[2] = 32'h84;
        pulses = 0;
        for (int i = 0; i < 40 && pulses < 3; i++) begin
            @(posedge clk);
            #1;
            if (rdy[2] === 1'b1) begin
                t[pulses] = cyc; dat[pulses] = rdata[2]; pulses++;
            end
        end
        rd[2] = 1'b0;
        vectors++;
        if (pulses != 3) begin
            miscompares++; $display("[TB] FAIL b2b_pulses: got %0d, want 3", pulses);
        end else begin
            vectors++;
            if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
                miscompares++; $display("[TB] FAIL b2b_spacing: got %0d,%0d, want 4,4", t[1] - t[0], t[2] - t[1]);
            end
            vectors++;
            if (dat[0] !== 32'hA5A50001 || dat[1] !== 32'h5A5A0002 || dat[2] !== 32'h5A5A0002) begin
                miscompares++; $display("[TB] FAIL b2b_data: got %h %h %h, want a5a50001 5a5a0002 5a5a0002", dat[0], dat[1], dat[2]);
            end
        end
        repeat (2) @(posedge clk);
    endtask

    // Random traffic over a small word pool plus misaligned, out-of-range and conflicting requests.
    task automatic test_random(input int d, input int n);
        logic [31:0] a, data, got_data, exp_data; logic r, w, got_err, exp_err;
        int edges, kind; bit quiet_ok, strobe_ok;
        for (int k = 0; k < n; k++) begin
            kind = $urandom_range(0, 9);
            a = 32'(64 + $urandom_range(0, 7)) * 32'd4;
            r = 1'($urandom_range(0, 1)); w = ~r;
            case (kind)
                0:       a = a | 32'($urandom_range(1, 3));
                1:       a = ($urandom | 32'h0000_0400) & ~32'h3;
                2:       begin r = 1'b1; w = 1'b1; end
                default: ;
            endcase
            data = $urandom;
            exp_err = (r && w) || (a[1:0] != 2'b00) || (a >= 32'd1024);
            run_req(d, r, w, a, data, got_data, got_err, edges, quiet_ok, strobe_ok);
            vectors++;
            if (edges !== wait_of[d] + 1 || got_err !== exp_err || !quiet_ok || !strobe_ok) begin
                miscompares++;
                $display("[TB] FAIL rand d%0d #%0d a=%h r=%b w=%b: got edges=%0d err=%b quiet=%b single=%b, want edges=%0d err=%b quiet=1 single=1",
                         d, k, a, r, w, edges, got_err, quiet_ok, strobe_ok, wait_of[d] + 1, exp_err);
            end
            exp_data = (exp_err || w) ? 32'd0 : model_mem[d][a[9:2]];
            if (exp_err || w || model_valid[d][a[9:2]]) begin
                vectors++;
                if (got_data !== exp_data) begin
                    miscompares++; $display("[TB] FAIL rand_data d%0d #%0d a=%h: got %h, want %h", d, k, a, got_data, exp_data);
                end
            end
            if (w && !exp_err) begin
                model_mem[d][a[9:2]] = data; model_valid[d][a[9:2]] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 256; i++) begin
                model_mem[d][i] = 32'd0; model_valid[d][i] = 1'b0;
            end
        test_reset();
        test_basic();
        test_directed(0, 0, 1, 32'h40, 32'hAAAA5555, 32'h0, 0, "store_40_old");
        test_reset_abort(3, "abort_resp");
        test_reset_abort(1, "abort_busy");
        test_back_to_back();
        for (int d = 0; d < 3; d++) test_random(d, 30);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
